// File: rtl/mem_stage_pkg.sv
// Shared types for the LA32R memory-access stage.
// Bus widths, EX->MS field layout and MS FSM encodings.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 79;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_BUS_WD = 39;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_WAIT = 2'd1,
    MS_HOLD = 2'd2
  } ms_state_t;

  typedef struct packed {
    logic        sext;
    logic        store;
    logic [1:0]  size;
    logic [3:0]  mdop;
    logic        load;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
  } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Sub-word load alignment and extension.
// Ports: rdata/addr/size/sext in, 32-bit aligned value out.
import mem_stage_pkg::*;

module mem_stage_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] value
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    unique case (addr)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = 8'h00;
    endcase
  end

  assign h = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    value = rdata;
    unique case (1'b1)
      size[0]: value = {{24{sext & b[7]}}, b};
      size[1]: value = {{16{sext & h[15]}}, h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// LA32R memory-access stage: waits for load data, aligns it,
// picks mul/div results, forwards to ID and hands off to WB.
import mem_stage_pkg::*;

module mem_stage (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_forward_bus,
  output logic                       ms_to_ds_valid,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       data_sram_data_ok,
  input  logic [63:0]                mul_result,
  input  logic [31:0]                div_quotient,
  input  logic [31:0]                div_remainder
);

  logic        ms_valid;
  es_to_ms_t   ms_bus;
  ms_state_t   state;
  logic [31:0] rdata_buf;
  logic        ms_ready_go;
  logic [31:0] load_src;
  logic [31:0] load_value;
  logic [31:0] final_result;
  logic        fwd_en;
  logic        load_wait;

  assign ms_ready_go = !ms_bus.load
                     | data_sram_data_ok
                     | (state == MS_HOLD);
  assign ms_allowin = !ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign ms_to_ds_valid = ms_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (ms_allowin) begin
      ms_bus <= es_to_ms_t'(es_to_ms_bus);
    end
  end

  // A retire/accept always restarts the FSM; otherwise only a
  // valid load that cannot leave yet advances it. Data that
  // arrives while WB stalls is parked in rdata_buf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MS_IDLE;
      rdata_buf <= 32'h0;
    end else if (ms_allowin) begin
      state <= MS_IDLE;
    end else if (ms_valid && ms_bus.load) begin
      unique case (state)
        MS_IDLE, MS_WAIT: begin
          if (data_sram_data_ok) begin
            rdata_buf <= data_sram_rdata;
            state     <= MS_HOLD;
          end else begin
            state <= MS_WAIT;
          end
        end
        MS_HOLD: state <= MS_HOLD;
        default: state <= MS_IDLE;
      endcase
    end
  end

  assign load_src = (state == MS_HOLD) ? rdata_buf : data_sram_rdata;

  mem_stage_load_align u_align (
    .rdata (load_src),
    .addr  (ms_bus.alu[1:0]),
    .size  (ms_bus.size),
    .sext  (ms_bus.sext),
    .value (load_value)
  );

  always_comb begin
    final_result = ms_bus.alu;
    unique case (1'b1)
      ms_bus.mdop[0]: final_result = mul_result[31:0];
      ms_bus.mdop[1]: final_result = mul_result[63:32];
      ms_bus.mdop[2]: final_result = div_quotient;
      ms_bus.mdop[3]: final_result = div_remainder;
      ms_bus.load:    final_result = load_value;
      default:        final_result = ms_bus.alu;
    endcase
  end

  assign fwd_en    = ms_valid & ms_bus.gr_we & (ms_bus.dest != 5'd0);
  assign load_wait = ms_valid & ms_bus.load & !ms_ready_go;

  assign ms_to_ws_bus = {ms_bus.gr_we, ms_bus.dest,
                         final_result, ms_bus.pc};
  assign ms_to_ds_forward_bus = {load_wait, fwd_en,
                                 ms_bus.dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage.
// Stimulus pushes expected WB handoffs; a monitor pops on transfer.
import mem_stage_pkg::*;

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [78:0] es_to_ms_bus;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic [38:0] ms_to_ds_forward_bus;
  logic        ms_to_ds_valid;
  logic [31:0] data_sram_rdata;
  logic        data_sram_data_ok;
  logic [63:0] mul_result;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;

  typedef struct packed {
    logic        we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk                  (clk),
    .reset                (reset),
    .ws_allowin           (ws_allowin),
    .ms_allowin           (ms_allowin),
    .es_to_ms_valid       (es_to_ms_valid),
    .es_to_ms_bus         (es_to_ms_bus),
    .ms_to_ws_valid       (ms_to_ws_valid),
    .ms_to_ws_bus         (ms_to_ws_bus),
    .ms_to_ds_forward_bus (ms_to_ds_forward_bus),
    .ms_to_ds_valid       (ms_to_ds_valid),
    .data_sram_rdata      (data_sram_rdata),
    .data_sram_data_ok    (data_sram_data_ok),
    .mul_result           (mul_result),
    .div_quotient         (div_quotient),
    .div_remainder        (div_remainder)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [78:0] mk(
    input logic sext, input logic store, input logic [1:0] size,
    input logic [3:0] mdop, input logic load, input logic we,
    input logic [4:0] dest, input logic [31:0] alu,
    input logic [31:0] pc);
    es_to_ms_t b;
    b = '{sext, store, size, mdop, load, we, dest, alu, pc};
    return 79'(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Monitor: every WB transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        check("unexpected_retire", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ret_pc", ms_to_ws_bus[31:0], e.pc);
        check("ret_result", ms_to_ws_bus[63:32], e.result);
        check("ret_dest", 32'(ms_to_ws_bus[68:64]), 32'(e.dest));
        check("ret_we", 32'(ms_to_ws_bus[69]), 32'(e.we));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_rdata = '0;
    data_sram_data_ok = 1'b0;
    mul_result = '0;
    div_quotient = '0;
    div_remainder = '0;
    step();
    step();
    reset = 1'b0;
    sample();
    check("rst_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("rst_ds_valid", 32'(ms_to_ds_valid), 32'd0);
    check("rst_fwd_en", 32'(ms_to_ds_forward_bus[37]), 32'd0);
    check("rst_allowin", 32'(ms_allowin), 32'd1);

    // 1: ld.b addr 3, signed, data same cycle
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 0, 2'b01, 4'h0, 1, 1, 5'd5,
                      32'h0000_1003, 32'h100);
    sb.push_back('{1'b1, 5'd5, 32'hFFFF_FF80, 32'h100});
    step();
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF_1234;
    sample();
    check("ldb_load_wait", 32'(ms_to_ds_forward_bus[38]), 32'd0);
    check("ldb_fwd_en", 32'(ms_to_ds_forward_bus[37]), 32'd1);
    step();
    data_sram_data_ok = 1'b0;
    sample();
    check("ldb_one_cycle", 32'(ms_to_ws_valid), 32'd0);

    // 2: ld.hu addr 2, data 3 cycles late
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 0, 2'b10, 4'h0, 1, 1, 5'd6,
                      32'h0000_2002, 32'h104);
    sb.push_back('{1'b1, 5'd6, 32'h0000_80FF, 32'h104});
    step();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("ldhu_load_wait", 32'(ms_to_ds_forward_bus[38]), 32'd1);
      check("ldhu_allowin", 32'(ms_allowin), 32'd0);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h80FF_1234;
    // back-to-back: ld.w accepted the cycle ld.hu retires
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 0, 2'b00, 4'h0, 1, 1, 5'd7,
                      32'h0000_3000, 32'h108);
    sb.push_back('{1'b1, 5'd7, 32'hDEAD_BEEF, 32'h108});
    sample();
    check("b2b_allowin", 32'(ms_allowin), 32'd1);
    step();

    // 3: ld.w, data arrives while WB stalls
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_rdata = 32'hDEAD_BEEF;
    sample();
    check("ldw_ws_valid", 32'(ms_to_ws_valid), 32'd1);
    check("ldw_allowin", 32'(ms_allowin), 32'd0);
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata = 32'h1111_1111;
    for (int i = 0; i < 2; i++) begin
      sample();
      check("hold_result", ms_to_ds_forward_bus[31:0], 32'hDEAD_BEEF);
      check("hold_ws_valid", 32'(ms_to_ws_valid), 32'd1);
      check("hold_load_wait", 32'(ms_to_ds_forward_bus[38]), 32'd0);
      step();
    end
    ws_allowin = 1'b1;
    sample();
    step();
    sample();
    check("hold_retired", 32'(ms_to_ws_valid), 32'd0);
    check("hold_allowin", 32'(ms_allowin), 32'd1);

    // 4: mulh.w then mod.w back to back
    mul_result = 64'h1234_5678_9ABC_DEF0;
    div_remainder = 32'd7;
    div_quotient = 32'h5555_AAAA;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 0, 2'b00, 4'b0010, 0, 1, 5'd8,
                      32'hAAAA_0000, 32'h10C);
    sb.push_back('{1'b1, 5'd8, 32'h1234_5678, 32'h10C});
    step();
    es_to_ms_bus = mk(0, 0, 2'b00, 4'b1000, 0, 1, 5'd9,
                      32'hBBBB_0000, 32'h110);
    sb.push_back('{1'b1, 5'd9, 32'd7, 32'h110});
    sample();
    check("mulh_allowin", 32'(ms_allowin), 32'd1);
    step();
    es_to_ms_valid = 1'b0;
    sample();
    check("mod_ws_valid", 32'(ms_to_ws_valid), 32'd1);
    step();

    // 5: stray data_ok during st.w and while idle
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 1, 2'b00, 4'h0, 0, 0, 5'd0,
                      32'h0000_3000, 32'h114);
    sb.push_back('{1'b0, 5'd0, 32'h0000_3000, 32'h114});
    step();
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_F00D;
    sample();
    check("st_ws_valid", 32'(ms_to_ws_valid), 32'd1);
    check("st_fwd_en", 32'(ms_to_ds_forward_bus[37]), 32'd0);
    check("st_result", ms_to_ds_forward_bus[31:0], 32'h0000_3000);
    step();
    data_sram_data_ok = 1'b0;
    ws_allowin = 1'b1;
    sample();
    step();
    data_sram_data_ok = 1'b1;
    sample();
    check("idle_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("idle_ds_valid", 32'(ms_to_ds_valid), 32'd0);
    step();
    data_sram_data_ok = 1'b0;

    // 6: reset mid-WAIT, late data_ok ignored
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(0, 0, 2'b00, 4'h0, 1, 1, 5'd10,
                      32'h0000_4000, 32'h118);
    step();
    es_to_ms_valid = 1'b0;
    step();
    sample();
    check("wait_load_wait", 32'(ms_to_ds_forward_bus[38]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("rst_mid_ds_valid", 32'(ms_to_ds_valid), 32'd0);
    step();
    reset = 1'b0;
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h9999_9999;
    sample();
    check("late_ok_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("late_ok_allowin", 32'(ms_allowin), 32'd1);
    step();
    data_sram_data_ok = 1'b0;

    // ld.h signed after reset, data one cycle late
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk(1, 0, 2'b10, 4'h0, 1, 1, 5'd11,
                      32'h0000_5000, 32'h11C);
    sb.push_back('{1'b1, 5'd11, 32'hFFFF_8001, 32'h11C});
    step();
    es_to_ms_valid = 1'b0;
    sample();
    check("ldh_load_wait", 32'(ms_to_ds_forward_bus[38]), 32'd1);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_8001;
    sample();
    step();
    data_sram_data_ok = 1'b0;
    step();
    sample();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
